// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
//   Bundles the byte-write side, the serial line and the status flags of
//   uart_tx_fifo into one interface.
//
//   Handshake: wr_i is a one-sided strobe with no ready signal. A byte on
//   data_i is taken on every rising edge where wr_i=1 and full_o=0. A write
//   seen while full_o=1 is dropped, and ovf_o pulses for the following cycle.
//   The producer watches full_o or count_o to avoid drops.
//
//   Signals:
//     baud_i   [15:0]  half-bit divisor (bit period = 2*(baud_i+1) clocks)
//     wr_i             write strobe
//     data_i   [7:0]   byte to queue
//     tx_o             serial line, idle high
//     full_o           FIFO holds DEPTH entries
//     empty_o          FIFO holds no entries
//     count_o  [CW-1:0] FIFO occupancy
//     busy_o           transmitter FSM not idle
//     ovf_o            one-cycle pulse: a write was dropped
//     state_o  [2:0]   transmitter FSM state, for observation
//
//   Modports:
//     master - the producer (drives baud_i/wr_i/data_i)
//     slave  - the uart_tx_fifo block
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   baud_i;
    logic          wr_i;
    logic [7:0]    data_i;
    logic          tx_o;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          busy_o;
    logic          ovf_o;
    logic [2:0]    state_o;

    modport master (
        output baud_i, wr_i, data_i,
        input  tx_o, full_o, empty_o, count_o, busy_o, ovf_o, state_o
    );

    modport slave (
        input  baud_i, wr_i, data_i,
        output tx_o, full_o, empty_o, count_o, busy_o, ovf_o, state_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding an 8-bit UART transmitter. Frame format:
//   start(0), 8 data bits LSB first, optional parity bit, STOP_BITS stop bits.
//   Back-to-back frames are sent without an idle gap while the FIFO has data.
//
//   Parameters:
//     DEPTH     FIFO entries, power of two in 2..64
//     PARITY    0 none, 1 even, 2 odd
//     STOP_BITS 1 or 2
//
//   Ports:
//     clk_i   sole clock, rising edge
//     rst_i   synchronous active-high reset (aborts any frame, empties FIFO)
//     bus     uart_tx_fifo_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH     = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          pop;
    logic [7:0]    head;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [16:0]   timer_q, timer_d;
    logic [15:0]   baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;

    logic          bit_end;
    logic          last_stop;
    logic          start_frame;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Fullness is judged on the registered count, so a pop on the same edge
    // never makes room for a write that arrives while full.
    assign wr_ok = bus.wr_i && !full;
    assign head  = mem_q[rd_ptr_q];

    // Bit period is 2*(baud+1) clocks, so the final timer value is 2*baud+1.
    assign bit_end   = (timer_q == {baud_q, 1'b1});
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = bus.wr_i && full;

        // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter next-state and registered line value
    //   tx_d is the line level for the state being entered, so tx_o changes
    //   on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 17'd1;
        baud_d      = baud_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        par_d       = par_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    timer_d    = '0;
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    tx_d    = 1'b1;
                    if (last_stop) begin
                        // Chain straight into the next frame when data waits.
                        if (!empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop the head byte, snapshot the divisor so a baud
        // change only affects the next frame, and precompute parity.
        if (start_frame) begin
            pop        = 1'b1;
            state_d    = S_START;
            timer_d    = '0;
            baud_d     = bus.baud_i;
            shift_d    = head;
            bit_idx_d  = 3'd0;
            stop_idx_d = 1'b0;
            par_d      = (^head) ^ (PARITY == 2);
            tx_d       = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            baud_q     <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx_o    = tx_q;
    assign bus.full_o  = full;
    assign bus.empty_o = empty;
    assign bus.count_o = count_q;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.ovf_o   = ovf_q;
    assign bus.state_o = state_q;

endmodule
